execute_stage: RTL and testbench

EXECUTE_STAGE -- requirements
Module: execute_stage

---
 rtl/execute_stage_if.sv | 30 +++
 rtl/execute_stage.sv | 136 +++++++++++++
 tb/tb_execute_stage.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/execute_stage_if.sv
// Handshake and writeback bundle between operand fetch and the execute stage.
// Operands are presented on in_valid/in_ready; registered writeback and flags come back.
// Backpressure is the single in_ready level driven by the stage.
interface execute_stage_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        op;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [ADDR_W-1:0] rd_in;
    logic              write_enable;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] write_data;
    logic              flag_z;
    logic              flag_c;
    logic              illegal;

    modport master (
        output in_valid, op, op_a, op_b, rd_in,
        input  in_ready, write_enable, rd, write_data, flag_z, flag_c, illegal
    );

    modport slave (
        input  in_valid, op, op_a, op_b, rd_in,
        output in_ready, write_enable, rd, write_data, flag_z, flag_c, illegal
    );
endinterface

// File: rtl/execute_stage.sv
// ALU execute stage with registered writeback; EXECUTE_STAGE_MUL_EN adds an iterative shift-add MUL.
// Latency: 1 cycle for single-cycle ops, DATA_W+1 cycles for MUL.
// Backpressure: in_ready drops only while a MUL is iterating.
module execute_stage #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic           clk,
    input  logic           rst,
    execute_stage_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WB   = 2'd2;
`ifdef EXECUTE_STAGE_MUL_EN
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam int         CNT_W  = $clog2(DATA_W) + 1;
`endif

    logic [1:0]        state;
    logic              accept;
    logic              we_q, ill_q, fz_q, fc_q;
    logic [ADDR_W-1:0] rd_q;
    logic [DATA_W-1:0] wd_q;

    logic [DATA_W-1:0] alu_res;
    logic              alu_c, alu_legal, alu_wr;
    logic [DATA_W:0]   sum, diff, shl_ext, shr_ext;
    logic [2:0]        sh;

    assign sh      = bus.op_b[2:0];
    assign sum     = {1'b0, bus.op_a} + {1'b0, bus.op_b};
    assign diff    = {1'b0, bus.op_a} - {1'b0, bus.op_b};
    // One spare bit on each side catches the last bit shifted out; shift by 0 leaves it 0.
    assign shl_ext = {1'b0, bus.op_a} << sh;
    assign shr_ext = {bus.op_a, 1'b0} >> sh;

`ifdef EXECUTE_STAGE_MUL_EN
    logic                alu_mul, mul_last;
    logic [2*DATA_W-1:0] m_cand, m_prod, prod_nxt;
    logic [DATA_W-1:0]   m_plier;
    logic [CNT_W-1:0]    m_cnt;
    logic [ADDR_W-1:0]   m_rd;

    assign prod_nxt      = m_prod + (m_plier[0] ? m_cand : '0);
    assign mul_last      = (m_cnt == CNT_W'(DATA_W - 1));
    assign bus.in_ready  = (state != S_MUL);
`else
    assign bus.in_ready  = 1'b1;
`endif

    assign accept           = bus.in_valid && bus.in_ready;
    assign bus.write_enable = we_q;
    assign bus.illegal      = ill_q;
    assign bus.rd           = rd_q;
    assign bus.write_data   = wd_q;
    assign bus.flag_z       = fz_q;
    assign bus.flag_c       = fc_q;

    always_comb begin
        alu_res   = '0;
        alu_c     = 1'b0;
        alu_legal = 1'b1;
        alu_wr    = 1'b1;
`ifdef EXECUTE_STAGE_MUL_EN
        alu_mul   = 1'b0;
`endif
        case (bus.op)
            4'd0: begin alu_res = sum[DATA_W-1:0];  alu_c = sum[DATA_W];  end
            4'd1: begin alu_res = diff[DATA_W-1:0]; alu_c = diff[DATA_W]; end
            4'd2: alu_res = bus.op_a & bus.op_b;
            4'd3: alu_res = bus.op_a | bus.op_b;
            4'd4: alu_res = bus.op_a ^ bus.op_b;
            4'd5: begin alu_res = shl_ext[DATA_W-1:0]; alu_c = shl_ext[DATA_W]; end
            4'd6: begin alu_res = shr_ext[DATA_W:1];   alu_c = shr_ext[0];      end
            4'd7: alu_res = bus.op_a;
`ifdef EXECUTE_STAGE_MUL_EN
            4'd8: alu_mul = 1'b1;
`endif
            4'd9: begin alu_res = diff[DATA_W-1:0]; alu_c = diff[DATA_W]; alu_wr = 1'b0; end
            default: begin alu_legal = 1'b0; alu_wr = 1'b0; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            we_q  <= 1'b0;
            ill_q <= 1'b0;
            rd_q  <= '0;
            wd_q  <= '0;
            fz_q  <= 1'b0;
            fc_q  <= 1'b0;
        end else begin
            we_q  <= 1'b0;
            ill_q <= 1'b0;
`ifdef EXECUTE_STAGE_MUL_EN
            if (state == S_MUL) begin
                m_prod  <= prod_nxt;
                m_cand  <= m_cand << 1;
                m_plier <= m_plier >> 1;
                m_cnt   <= m_cnt + 1'b1;
                if (mul_last) begin
                    we_q  <= 1'b1;
                    rd_q  <= m_rd;
                    wd_q  <= prod_nxt[DATA_W-1:0];
                    fz_q  <= (prod_nxt[DATA_W-1:0] == '0);
                    fc_q  <= |prod_nxt[2*DATA_W-1:DATA_W];
                    state <= S_WB;
                end
            end else if (accept && alu_mul) begin
                m_cand  <= {{DATA_W{1'b0}}, bus.op_a};
                m_plier <= bus.op_b;
                m_prod  <= '0;
                m_cnt   <= '0;
                m_rd    <= bus.rd_in;
                state   <= S_MUL;
            end else
`endif
            if (accept) begin
                state <= S_WB;
                ill_q <= !alu_legal;
                if (alu_legal) begin
                    fz_q <= (alu_res == '0);
                    fc_q <= alu_c;
                end
                if (alu_wr) begin
                    we_q <= 1'b1;
                    rd_q <= bus.rd_in;
                    wd_q <= alu_res;
                end
            end else begin
                state <= S_IDLE;
            end
        end
    end
endmodule

// File: tb/tb_execute_stage.sv
// Directed checks of execute_stage: reset, every opcode, back-to-back issue, flags, illegal ops, MUL/abort when enabled.
module tb_execute_stage;
    logic clk = 1'b0;
    logic rst;
    int   total  = 0;
    int   passed = 0;

    execute_stage_if #(.DATA_W(8), .ADDR_W(5)) bus ();

    execute_stage #(.DATA_W(8), .ADDR_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive(input logic v, input logic [3:0] o, input logic [7:0] a,
                         input logic [7:0] b, input logic [4:0] r);
        bus.in_valid = v;
        bus.op       = o;
        bus.op_a     = a;
        bus.op_b     = b;
        bus.rd_in    = r;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_we"},    32'(bus.write_enable), 32'd0);
        chk({tag, "_ill"},   32'(bus.illegal),      32'd0);
        chk({tag, "_rd"},    32'(bus.rd),           32'd0);
        chk({tag, "_wd"},    32'(bus.write_data),   32'd0);
        chk({tag, "_z"},     32'(bus.flag_z),       32'd0);
        chk({tag, "_c"},     32'(bus.flag_c),       32'd0);
        chk({tag, "_rdy"},   32'(bus.in_ready),     32'd1);
    endtask

    typedef struct {
        logic [3:0] op;
        logic [7:0] a, b;
        logic [4:0] r;
        logic [7:0] wd;
        logic       c, z;
    } vec_t;

    vec_t vecs[10] = '{
        '{4'd2, 8'hF0, 8'h0F, 5'd0,  8'h00, 1'b0, 1'b1},
        '{4'd3, 8'hA0, 8'h05, 5'd31, 8'hA5, 1'b0, 1'b0},
        '{4'd4, 8'hFF, 8'hFF, 5'd7,  8'h00, 1'b0, 1'b1},
        '{4'd7, 8'h5A, 8'h33, 5'd2,  8'h5A, 1'b0, 1'b0},
        '{4'd5, 8'h81, 8'h01, 5'd4,  8'h02, 1'b1, 1'b0},
        '{4'd5, 8'hC3, 8'h00, 5'd9,  8'hC3, 1'b0, 1'b0},
        '{4'd6, 8'h0C, 8'h03, 5'd10, 8'h01, 1'b1, 1'b0},
        '{4'd6, 8'h81, 8'h09, 5'd11, 8'h40, 1'b1, 1'b0},
        '{4'd0, 8'h01, 8'hFF, 5'd12, 8'h00, 1'b1, 1'b1},
        '{4'd1, 8'h02, 8'h03, 5'd13, 8'hFF, 1'b1, 1'b0}
    };

    initial begin
        rst = 1'b1;
        drive(1'b0, 4'd0, 8'h00, 8'h00, 5'd0);
        tick();
        tick();
        chk_reset("reset");
        rst = 1'b0;

        // ADD with carry-out
        drive(1'b1, 4'd0, 8'hF0, 8'h20, 5'd5);
        tick();
        drive(1'b0, 4'd0, 8'h00, 8'h00, 5'd0);
        chk("add_we", 32'(bus.write_enable), 32'd1);
        chk("add_rd", 32'(bus.rd),           32'd5);
        chk("add_wd", 32'(bus.write_data),   32'h10);
        chk("add_c",  32'(bus.flag_c),       32'd1);
        chk("add_z",  32'(bus.flag_z),       32'd0);
        tick();
        chk("add_we_drop", 32'(bus.write_enable), 32'd0);
        chk("add_wd_hold", 32'(bus.write_data),   32'h10);
        chk("add_rd_hold", 32'(bus.rd),           32'd5);

        // SUB then CMP back-to-back
        drive(1'b1, 4'd1, 8'h05, 8'h05, 5'd3);
        tick();
        chk("sub_we", 32'(bus.write_enable), 32'd1);
        chk("sub_wd", 32'(bus.write_data),   32'h00);
        chk("sub_z",  32'(bus.flag_z),       32'd1);
        chk("sub_c",  32'(bus.flag_c),       32'd0);
        chk("sub_rd", 32'(bus.rd),           32'd3);
        drive(1'b1, 4'd9, 8'h03, 8'h07, 5'd20);
        tick();
        drive(1'b0, 4'd0, 8'h00, 8'h00, 5'd0);
        chk("cmp_we", 32'(bus.write_enable), 32'd0);
        chk("cmp_c",  32'(bus.flag_c),       32'd1);
        chk("cmp_z",  32'(bus.flag_z),       32'd0);
        chk("cmp_wd", 32'(bus.write_data),   32'h00);
        chk("cmp_rd", 32'(bus.rd),           32'd3);
        tick();

        // Back-to-back single-cycle ops, one result per cycle
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].r);
            tick();
            chk($sformatf("v%0d_we", i), 32'(bus.write_enable), 32'd1);
            chk($sformatf("v%0d_wd", i), 32'(bus.write_data),   32'(vecs[i].wd));
            chk($sformatf("v%0d_rd", i), 32'(bus.rd),           32'(vecs[i].r));
            chk($sformatf("v%0d_c", i),  32'(bus.flag_c),       32'(vecs[i].c));
            chk($sformatf("v%0d_z", i),  32'(bus.flag_z),       32'(vecs[i].z));
            chk($sformatf("v%0d_rdy", i), 32'(bus.in_ready),    32'd1);
        end
        // Inputs change without in_valid: nothing may move
        drive(1'b0, 4'd0, 8'h00, 8'h00, 5'd1);
        tick();
        chk("idle_we", 32'(bus.write_enable), 32'd0);
        chk("idle_wd", 32'(bus.write_data),   32'hFF);
        chk("idle_c",  32'(bus.flag_c),       32'd1);
        chk("idle_z",  32'(bus.flag_z),       32'd0);

        // Illegal opcode 0xC
        drive(1'b1, 4'hC, 8'h00, 8'h00, 5'd6);
        tick();
        drive(1'b0, 4'd0, 8'h00, 8'h00, 5'd0);
        chk("illC_pulse", 32'(bus.illegal),      32'd1);
        chk("illC_we",    32'(bus.write_enable), 32'd0);
        chk("illC_c",     32'(bus.flag_c),       32'd1);
        chk("illC_z",     32'(bus.flag_z),       32'd0);
        chk("illC_rd",    32'(bus.rd),           32'd13);
        tick();
        chk("illC_end",   32'(bus.illegal),      32'd0);

`ifdef EXECUTE_STAGE_MUL_EN
        // MUL 0x10*0x11 = 0x110
        drive(1'b1, 4'd8, 8'h10, 8'h11, 5'd17);
        tick();
        drive(1'b1, 4'd0, 8'hAA, 8'h55, 5'd2);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("mul_rdy%0d", i), 32'(bus.in_ready),     32'd0);
            chk($sformatf("mul_we%0d", i),  32'(bus.write_enable), 32'd0);
            if (i == 7) drive(1'b0, 4'd0, 8'h00, 8'h00, 5'd0);
            tick();
        end
        chk("mul_we", 32'(bus.write_enable), 32'd1);
        chk("mul_wd", 32'(bus.write_data),   32'h10);
        chk("mul_rd", 32'(bus.rd),           32'd17);
        chk("mul_c",  32'(bus.flag_c),       32'd1);
        chk("mul_z",  32'(bus.flag_z),       32'd0);
        chk("mul_rdy", 32'(bus.in_ready),    32'd1);
        tick();

        // Reset four cycles into a MUL aborts it
        drive(1'b1, 4'd8, 8'h03, 8'h05, 5'd8);
        tick();
        drive(1'b0, 4'd0, 8'h00, 8'h00, 5'd0);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset("mul_abort");
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("abort_we%0d", i), 32'(bus.write_enable), 32'd0);
        end
`else
        // Opcode 8 without the multiplier is illegal; stage never stalls
        drive(1'b1, 4'd8, 8'h10, 8'h11, 5'd17);
        tick();
        drive(1'b0, 4'd0, 8'h00, 8'h00, 5'd0);
        chk("ill8_pulse", 32'(bus.illegal),      32'd1);
        chk("ill8_we",    32'(bus.write_enable), 32'd0);
        chk("ill8_c",     32'(bus.flag_c),       32'd1);
        chk("ill8_z",     32'(bus.flag_z),       32'd0);
        chk("ill8_wd",    32'(bus.write_data),   32'hFF);
        chk("ill8_rdy",   32'(bus.in_ready),     32'd1);
        tick();
        chk("ill8_end",   32'(bus.illegal),      32'd0);
`endif

        // Reset overrides a simultaneous accept
        drive(1'b1, 4'd0, 8'h12, 8'h34, 5'd9);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b0, 4'd0, 8'h00, 8'h00, 5'd0);
        chk_reset("rst_acc");
        tick();
        chk("rst_acc_we", 32'(bus.write_enable), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
